fe_phase_sequencer: RTL and testbench

//  Drives the fetch/execute flip-flop. Steps through fetch and execute

---
 rtl/fe_phase_sequencer_if.sv | 28 ++
 rtl/fe_phase_sequencer.sv | 146 ++++++++++++++
 tb/tb_fe_phase_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fe_phase_sequencer_if.sv
// Bundles the sequencer's control inputs, the fe flip-flop feedback and the status/trigger
// outputs. The master modport drives the sequencer; the slave modport belongs to the sequencer.
interface fe_phase_sequencer_if #(
  parameter int STEP_W = 3
);
  logic              run;
  logic              step_req;
  logic              halt_req;
  logic              mem_ready;
  logic              exec_done;
  logic              fe_q;
  logic              trigger_set;
  logic              trigger_rst;
  logic [STEP_W-1:0] step;
  logic              in_exec;
  logic              busy;
  logic              phase_err;

  modport master (
    output run, step_req, halt_req, mem_ready, exec_done, fe_q,
    input  trigger_set, trigger_rst, step, in_exec, busy, phase_err
  );

  modport slave (
    input  run, step_req, halt_req, mem_ready, exec_done, fe_q,
    output trigger_set, trigger_rst, step, in_exec, busy, phase_err
  );
endinterface

// File: rtl/fe_phase_sequencer.sv
// Fetch/execute phase sequencer. It steps through fetch and execute micro-steps, stalls fetch on
// memory wait states, pulses the fe flip-flop triggers and checks the flip-flop feedback.
module fe_phase_sequencer #(
  parameter int FETCH_STEPS = 3,
  parameter int EXEC_STEPS  = 4,
  parameter int STEP_W      = 3
) (
  input  logic                clk,
  input  logic                rst,
  fe_phase_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_e;

  localparam logic [STEP_W-1:0] FETCH_LAST = STEP_W'(FETCH_STEPS - 1);
  localparam logic [STEP_W-1:0] EXEC_LAST  = STEP_W'(EXEC_STEPS - 1);
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              halt_pend_q, halt_pend_d;
  logic              ss_mode_q, ss_mode_d;
  logic              first_q, first_d;
  logic              trigger_set_q, trigger_set_d;
  logic              trigger_rst_q, trigger_rst_d;
  logic              in_exec_q, in_exec_d;
  logic              busy_q, busy_d;
  logic              phase_err_q, phase_err_d;

  logic halt_now;
  logic exec_end;
  logic fe_mismatch;

  // A halt request that arrives on the execute boundary cycle still counts at that boundary.
  assign halt_now = halt_pend_q | bus.halt_req;
  assign exec_end = (step_q == EXEC_LAST) | bus.exec_done;

  // first_q exempts the first cycle of a phase, while the flip-flop still shows the old phase.
  assign fe_mismatch = ~first_q & (((state_q == S_FETCH) &  bus.fe_q) |
                                   ((state_q == S_EXEC)  & ~bus.fe_q));

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case can infer a latch.
    state_d       = state_q;
    step_d        = step_q;
    halt_pend_d   = halt_pend_q;
    ss_mode_d     = ss_mode_q;
    first_d       = 1'b0;
    trigger_set_d = 1'b0;
    trigger_rst_d = 1'b0;
    phase_err_d   = phase_err_q | fe_mismatch;

    unique case (state_q)
      S_IDLE: begin
        step_d = '0;
        if (bus.step_req) begin
          state_d   = S_FETCH;
          ss_mode_d = 1'b1;
          first_d   = 1'b1;
        end else if (bus.run) begin
          state_d   = S_FETCH;
          ss_mode_d = 1'b0;
          first_d   = 1'b1;
        end
      end

      S_FETCH: begin
        halt_pend_d = halt_now;
        if (bus.mem_ready) begin
          if (step_q == FETCH_LAST) begin
            state_d       = S_EXEC;
            step_d        = '0;
            trigger_set_d = 1'b1;
            first_d       = 1'b1;
          end else begin
            step_d = step_q + STEP_ONE;
          end
        end
      end

      S_EXEC: begin
        halt_pend_d = halt_now;
        if (exec_end) begin
          step_d        = '0;
          trigger_rst_d = 1'b1;
          if (halt_now | ss_mode_q | ~bus.run) begin
            state_d     = S_IDLE;
            halt_pend_d = 1'b0;
          end else begin
            state_d = S_FETCH;
            first_d = 1'b1;
          end
        end else begin
          step_d = step_q + STEP_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        step_d  = '0;
      end
    endcase

    in_exec_d = (state_d == S_EXEC);
    busy_d    = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      step_q        <= '0;
      halt_pend_q   <= 1'b0;
      ss_mode_q     <= 1'b0;
      first_q       <= 1'b0;
      trigger_set_q <= 1'b0;
      trigger_rst_q <= 1'b0;
      in_exec_q     <= 1'b0;
      busy_q        <= 1'b0;
      phase_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      halt_pend_q   <= halt_pend_d;
      ss_mode_q     <= ss_mode_d;
      first_q       <= first_d;
      trigger_set_q <= trigger_set_d;
      trigger_rst_q <= trigger_rst_d;
      in_exec_q     <= in_exec_d;
      busy_q        <= busy_d;
      phase_err_q   <= phase_err_d;
    end
  end

  assign bus.trigger_set = trigger_set_q;
  assign bus.trigger_rst = trigger_rst_q;
  assign bus.step        = step_q;
  assign bus.in_exec     = in_exec_q;
  assign bus.busy        = busy_q;
  assign bus.phase_err   = phase_err_q;

endmodule

// File: tb/tb_fe_phase_sequencer.sv
// Bench for fe_phase_sequencer: directed scenarios plus randomized traffic, compared every cycle
// against a phase-level reference model that includes the external fe flip-flop.
module tb_fe_phase_sequencer;

  localparam int FETCH_STEPS = 3;
  localparam int EXEC_STEPS  = 4;
  localparam int STEP_W      = 3;

  localparam int PH_IDLE  = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_EXEC  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fe_phase_sequencer_if #(.STEP_W(STEP_W)) bus ();

  fe_phase_sequencer #(
    .FETCH_STEPS(FETCH_STEPS),
    .EXEC_STEPS (EXEC_STEPS),
    .STEP_W     (STEP_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_n  = 0;

  // Reference model: phase, micro-step, cycles already spent in the phase, pending flags.
  int m_phase;
  int m_step;
  int m_cyc;
  bit m_halt;
  bit m_ss;
  bit m_tset;
  bit m_trst;
  bit m_err;

  // External fe flip-flop: set by trigger_set, cleared by trigger_rst.
  bit fe_ff;
  int fe_mode;  // 0: real flip-flop, 1: random noise, 2: stuck at 0

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (tick %0d): got %0h, expected %0h", tag, tick_n, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_step  = 0;
    m_cyc   = 0;
    m_halt  = 0;
    m_ss    = 0;
    m_tset  = 0;
    m_trst  = 0;
    m_err   = 0;
    fe_ff   = 0;
  endtask

  task automatic model_clock(input bit run, input bit sreq, input bit hreq,
                             input bit mrdy, input bit edone, input bit fe);
    bit nset;
    bit nrst;
    nset = 0;
    nrst = 0;
    if (m_cyc > 0 && ((m_phase == PH_FETCH && fe) || (m_phase == PH_EXEC && !fe)))
      m_err = 1;
    if (m_phase == PH_IDLE) begin
      m_step = 0;
      if (sreq || run) begin
        m_phase = PH_FETCH;
        m_ss    = sreq;
        m_cyc   = 0;
      end
    end else if (m_phase == PH_FETCH) begin
      m_halt = m_halt | hreq;
      m_cyc++;
      if (mrdy) begin
        if (m_step == FETCH_STEPS - 1) begin
          nset    = 1;
          m_phase = PH_EXEC;
          m_step  = 0;
          m_cyc   = 0;
        end else begin
          m_step++;
        end
      end
    end else begin
      m_halt = m_halt | hreq;
      m_cyc++;
      if (m_step == EXEC_STEPS - 1 || edone) begin
        nrst   = 1;
        m_step = 0;
        if (m_halt || m_ss || !run) begin
          m_phase = PH_IDLE;
          m_halt  = 0;
        end else begin
          m_phase = PH_FETCH;
          m_cyc   = 0;
        end
      end else begin
        m_step++;
      end
    end
    m_tset = nset;
    m_trst = nrst;
  endtask

  task automatic compare_outputs(input string where);
    check({where, ".trigger_set"}, 32'(bus.trigger_set), 32'(m_tset));
    check({where, ".trigger_rst"}, 32'(bus.trigger_rst), 32'(m_trst));
    check({where, ".step"},        32'(bus.step),        32'(m_step));
    check({where, ".in_exec"},     32'(bus.in_exec),     32'(m_phase == PH_EXEC));
    check({where, ".busy"},        32'(bus.busy),        32'(m_phase != PH_IDLE));
    check({where, ".phase_err"},   32'(bus.phase_err),   32'(m_err));
  endtask

  // One clock cycle: drive fe_q, let the edge pass, advance model and flip-flop, sample at negedge.
  task automatic tick();
    bit fe_in;
    case (fe_mode)
      0:       fe_in = fe_ff;
      1:       fe_in = 1'($urandom);
      default: fe_in = 1'b0;
    endcase
    bus.fe_q = fe_in;
    @(posedge clk);
    if (m_tset)      fe_ff = 1;
    else if (m_trst) fe_ff = 0;
    model_clock(bus.run, bus.step_req, bus.halt_req, bus.mem_ready, bus.exec_done, fe_in);
    @(negedge clk);
    tick_n++;
    compare_outputs("cyc");
  endtask

  // Called at a negedge; reset takes effect without waiting for a clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_outputs("rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_outputs("rst_rel");
  endtask

  task automatic idle_inputs();
    bus.run       = 1'b0;
    bus.step_req  = 1'b0;
    bus.halt_req  = 1'b0;
    bus.mem_ready = 1'b1;
    bus.exec_done = 1'b0;
    bus.fe_q      = 1'b0;
  endtask

  initial begin
    int t_busy;
    int t0;
    int n_set;
    int n_rst;
    int guard;
    int tset_q[$];
    int trst_q[$];

    idle_inputs();
    fe_mode = 0;
    model_reset();
    @(negedge clk);

    // 1: reset, run low -> everything stays 0 in IDLE
    do_reset();
    bus.run = 1'b0;
    repeat (5) tick();
    check("s1_busy", 32'(bus.busy), 32'd0);

    // 2: free-running, no stalls -> 3-cycle fetch, 4-cycle execute, 7-cycle period
    do_reset();
    bus.run = 1'b1;
    t_busy = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.busy && t_busy < 0) t_busy = tick_n;
      if (bus.trigger_set) tset_q.push_back(tick_n);
      if (bus.trigger_rst) trst_q.push_back(tick_n);
    end
    check("s2_enough_pulses", 32'(tset_q.size() >= 2 && trst_q.size() >= 1), 32'd1);
    if (tset_q.size() >= 2 && trst_q.size() >= 1) begin
      check("s2_set_latency", 32'(tset_q[0] - t_busy), 32'd3);
      check("s2_rst_latency", 32'(trst_q[0] - tset_q[0]), 32'd4);
      check("s2_period",      32'(tset_q[1] - tset_q[0]), 32'd7);
    end

    // 3: two wait states at fetch step 1 -> step holds, trigger_set two cycles later
    do_reset();
    bus.run = 1'b1;
    tick();
    t0 = tick_n;
    tick();
    check("s3_step1", 32'(bus.step), 32'd1);
    bus.mem_ready = 1'b0;
    tick();
    tick();
    check("s3_hold", 32'(bus.step), 32'd1);
    bus.mem_ready = 1'b1;
    guard = 0;
    while (!bus.trigger_set && guard < 10) begin
      tick();
      guard++;
    end
    check("s3_set_seen", 32'(bus.trigger_set), 32'd1);
    check("s3_set_latency", 32'(tick_n - t0), 32'd5);

    // 4: single-step from IDLE -> one instruction, back to IDLE
    do_reset();
    bus.run = 1'b0;
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    n_set = 0;
    n_rst = 0;
    repeat (20) begin
      tick();
      n_set += int'(bus.trigger_set);
      n_rst += int'(bus.trigger_rst);
    end
    check("s4_n_set", 32'(n_set), 32'd1);
    check("s4_n_rst", 32'(n_rst), 32'd1);
    check("s4_idle",  32'(bus.busy), 32'd0);

    // 5: early exec_done at exec step 1, then halt during the next fetch
    do_reset();
    bus.run = 1'b1;
    guard = 0;
    while (!(m_phase == PH_EXEC && m_step == 1) && guard < 20) begin
      tick();
      guard++;
    end
    check("s5_reach_exec1", 32'(bus.in_exec && bus.step == 1), 32'd1);
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    check("s5_trst",    32'(bus.trigger_rst), 32'd1);
    check("s5_step0",   32'(bus.step), 32'd0);
    check("s5_refetch", 32'({bus.busy, bus.in_exec}), 32'b10);
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    n_rst = 0;
    guard = 0;
    while (bus.busy && guard < 30) begin
      tick();
      n_rst += int'(bus.trigger_rst);
      guard++;
    end
    check("s5_halted",    32'(bus.busy), 32'd0);
    check("s5_one_instr", 32'(n_rst), 32'd1);

    // 6: fe_q stuck at 0 -> sticky phase_err; then reset mid-execute
    do_reset();
    fe_mode = 2;
    bus.run = 1'b1;
    guard = 0;
    while (!bus.trigger_set && guard < 20) begin
      tick();
      guard++;
    end
    check("s6_exec_c1_ok", 32'(bus.phase_err), 32'd0);
    tick();
    tick();
    check("s6_err_set", 32'(bus.phase_err), 32'd1);
    repeat (3) tick();
    check("s6_err_sticky", 32'(bus.phase_err), 32'd1);
    guard = 0;
    while (!bus.in_exec && guard < 20) begin
      tick();
      guard++;
    end
    check("s6_in_exec", 32'(bus.in_exec), 32'd1);
    bus.run = 1'b0;
    do_reset();
    fe_mode = 0;
    repeat (4) tick();
    check("s6_no_trst", 32'(bus.trigger_rst), 32'd0);

    // Randomized traffic in segments, each started from reset
    for (int seg = 0; seg < 15; seg++) begin
      idle_inputs();
      do_reset();
      fe_mode = ($urandom_range(4) == 0) ? 1 : 0;
      for (int i = 0; i < 200; i++) begin
        bus.run       = ($urandom_range(9) < 7);
        bus.step_req  = ($urandom_range(9) == 0);
        bus.halt_req  = ($urandom_range(14) == 0);
        bus.mem_ready = ($urandom_range(3) != 0);
        bus.exec_done = ($urandom_range(4) == 0);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
